// File: rtl/calc_pkg.sv
// calc_pkg: key codes, operator encodings, keypad map and debounce FSM states
// shared by the keypad front end of the calculator.
package calc_pkg;
    localparam logic [4:0] KEY_0 = 5'd0, KEY_1 = 5'd1, KEY_2 = 5'd2, KEY_3 = 5'd3, KEY_4 = 5'd4;
    localparam logic [4:0] KEY_5 = 5'd5, KEY_6 = 5'd6, KEY_7 = 5'd7, KEY_8 = 5'd8, KEY_9 = 5'd9;
    localparam logic [4:0] KEY_ADD = 5'd10, KEY_SUB = 5'd11, KEY_MUL = 5'd12, KEY_DIV = 5'd13;
    localparam logic [4:0] KEY_EQ = 5'd14, KEY_CLR = 5'd15, KEY_BKSP = 5'd16;
    localparam logic [4:0] KEY_MS = 5'd17, KEY_MR = 5'd18, KEY_MC = 5'd19;

    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

    // Indexed by row*5 + col
    localparam logic [4:0] KEY_MAP [20] = '{
        KEY_7,   KEY_8, KEY_9,  KEY_DIV, KEY_BKSP,
        KEY_4,   KEY_5, KEY_6,  KEY_MUL, KEY_MC,
        KEY_1,   KEY_2, KEY_3,  KEY_SUB, KEY_MR,
        KEY_CLR, KEY_0, KEY_EQ, KEY_ADD, KEY_MS
    };

    typedef enum logic [1:0] {ST_IDLE, ST_CAND, ST_PRESSED} db_state_t;

    function automatic logic [4:0] key_code(input logic [1:0] row, input logic [2:0] col);
        return KEY_MAP[5'(row) * 5'd5 + 5'(col)];
    endfunction

    function automatic logic repeats(input logic [4:0] c);
        return c <= KEY_9 || c == KEY_BKSP;
    endfunction
endpackage

// File: rtl/keypad_col_scanner.sv
// keypad_col_scanner: drives the active-low columns, synchronizes the rows and
// reports one NONE / KEY / MULTI result per full 5-column scan.
module keypad_col_scanner
    import calc_pkg::*;
#(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [4:0] col_n,
    input  logic [3:0] row_n,
    output logic       scan_valid,
    output logic [4:0] scan_code,
    output logic       scan_none,
    output logic       scan_multi
);
    localparam int DW = $clog2(SCAN_DIV);

    logic          active;
    logic [2:0]    col;
    logic [DW-1:0] dwell;
    logic [3:0]    sync0, sync1;
    logic [1:0]    acc_cnt, col_cnt, tot, row_idx;
    logic [2:0]    sum;
    logic [4:0]    acc_code, cur_code;
    logic [3:0]    hits;
    logic          last_dwell;

    // Closure count saturates at 2: anything beyond one key is simply MULTI
    always_comb begin
        hits       = ~sync1;
        col_cnt    = hits == 4'd0 ? 2'd0 : (hits & (hits - 4'd1)) == 4'd0 ? 2'd1 : 2'd2;
        row_idx    = hits[0] ? 2'd0 : hits[1] ? 2'd1 : hits[2] ? 2'd2 : 2'd3;
        sum        = 3'(acc_cnt) + 3'(col_cnt);
        tot        = sum > 3'd1 ? 2'd2 : sum[1:0];
        cur_code   = col_cnt == 2'd1 ? key_code(row_idx, col) : acc_code;
        last_dwell = active && dwell == DW'(SCAN_DIV - 1);
        col_n      = active ? ~(5'd1 << col) : 5'b11111;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            active     <= 1'b0;
            col        <= '0;
            dwell      <= '0;
            sync0      <= '1;
            sync1      <= '1;
            acc_cnt    <= '0;
            acc_code   <= '0;
            scan_valid <= 1'b0;
            scan_code  <= '0;
            scan_none  <= 1'b0;
            scan_multi <= 1'b0;
        end else begin
            sync0      <= row_n;
            sync1      <= sync0;
            active     <= 1'b1;
            scan_valid <= 1'b0;
            if (last_dwell) begin
                dwell <= '0;
                col   <= col == 3'd4 ? 3'd0 : col + 3'd1;
                if (col == 3'd4) begin
                    scan_valid <= 1'b1;
                    scan_none  <= tot == 2'd0;
                    scan_multi <= tot == 2'd2;
                    scan_code  <= cur_code;
                    acc_cnt    <= '0;
                end else begin
                    acc_cnt  <= tot;
                    acc_code <= cur_code;
                end
            end else if (active) begin
                dwell <= dwell + 1'b1;
            end
        end
    end
endmodule

// File: rtl/keypad_decoder.sv
// keypad_decoder: debounces 4x5 keypad scan results into one-clock key pulses.
// Define KEY_REPEAT_EN to auto-repeat held digit and backspace keys.
module keypad_decoder
    import calc_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_DELAY   = 60,
    parameter int REPEAT_RATE    = 12
) (
    input  logic       clock,
    input  logic       reset_n,
    output logic [4:0] col_n,
    input  logic [3:0] row_n,
    output logic       dig_key,
    output logic [3:0] digit_val,
    output logic       op_key,
    output logic [1:0] op_sel,
    output logic       ex_key,
    output logic       bksp_key,
    output logic       clr_key,
    output logic       ms_key,
    output logic       mr_key,
    output logic       mc_key
);
    if (SCAN_DIV < 3 || DEBOUNCE_SCANS < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1 ||
        REPEAT_RATE > REPEAT_DELAY) begin : g_param_check
        $error("keypad_decoder: parameter out of range");
    end

    logic       scan_valid, scan_none, scan_multi;
    logic [4:0] scan_code;

    keypad_col_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clock      (clock),
        .reset_n    (reset_n),
        .col_n      (col_n),
        .row_n      (row_n),
        .scan_valid (scan_valid),
        .scan_code  (scan_code),
        .scan_none  (scan_none),
        .scan_multi (scan_multi)
    );

    db_state_t  state, state_nx;
    logic [7:0] cnt, cnt_nx, rcnt, rcnt_nx;
    logic [4:0] code, code_nx, fire_code;
    logic       is_key, same, press, rep_fire, fire, is_dig, is_op;

    assign is_key = scan_valid && !scan_none && !scan_multi;
    assign same   = is_key && scan_code == code;

`ifdef KEY_REPEAT_EN
    logic [15:0] rep, rep_nx;
    logic        rep_hit;
    // After the first repeat the counter rewinds so later repeats come every REPEAT_RATE scans
    always_comb begin
        rep_hit  = state == ST_PRESSED && same && repeats(code);
        rep_fire = rep_hit && rep + 16'd1 == 16'(REPEAT_DELAY);
        rep_nx   = press ? 16'd0 : rep_fire ? 16'(REPEAT_DELAY - REPEAT_RATE) : rep_hit ? rep + 16'd1 : rep;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= '0;
            rcnt  <= '0;
            code  <= '0;
`ifdef KEY_REPEAT_EN
            rep   <= '0;
`endif
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            rcnt  <= rcnt_nx;
            code  <= code_nx;
`ifdef KEY_REPEAT_EN
            rep   <= rep_nx;
`endif
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rcnt_nx  = rcnt;
        code_nx  = code;
        if (scan_valid) begin
            case (state)
                ST_IDLE: if (is_key) begin
                    code_nx  = scan_code;
                    cnt_nx   = 8'd1;
                    rcnt_nx  = '0;
                    state_nx = press ? ST_PRESSED : ST_CAND;
                end
                ST_CAND: if (press) begin
                    state_nx = ST_PRESSED;
                    rcnt_nx  = '0;
                end else if (same) begin
                    cnt_nx = cnt + 8'd1;
                end else if (is_key) begin
                    code_nx = scan_code;
                    cnt_nx  = 8'd1;
                end else begin
                    state_nx = ST_IDLE;
                end
                ST_PRESSED: begin
                    rcnt_nx  = scan_none ? rcnt + 8'd1 : 8'd0;
                    state_nx = scan_none && rcnt + 8'd1 == 8'(DEBOUNCE_SCANS) ? ST_IDLE : ST_PRESSED;
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        press     = is_key && ((state == ST_IDLE && DEBOUNCE_SCANS <= 1) ||
                    (state == ST_CAND && scan_code == code && cnt + 8'd1 == 8'(DEBOUNCE_SCANS)));
        fire      = press || rep_fire;
        fire_code = press ? scan_code : code;
        is_dig    = fire_code <= KEY_9;
        is_op     = fire_code >= KEY_ADD && fire_code <= KEY_DIV;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dig_key   <= 1'b0;
            digit_val <= '0;
            op_key    <= 1'b0;
            op_sel    <= '0;
            ex_key    <= 1'b0;
            bksp_key  <= 1'b0;
            clr_key   <= 1'b0;
            ms_key    <= 1'b0;
            mr_key    <= 1'b0;
            mc_key    <= 1'b0;
        end else begin
            dig_key  <= fire && is_dig;
            op_key   <= fire && is_op;
            ex_key   <= fire && fire_code == KEY_EQ;
            bksp_key <= fire && fire_code == KEY_BKSP;
            clr_key  <= fire && fire_code == KEY_CLR;
            ms_key   <= fire && fire_code == KEY_MS;
            mr_key   <= fire && fire_code == KEY_MR;
            mc_key   <= fire && fire_code == KEY_MC;
            if (fire && is_dig) digit_val <= fire_code[3:0];
            if (fire && is_op) op_sel <= 2'(fire_code - KEY_ADD);
        end
    end
endmodule

// File: tb/tb_keypad_decoder.sv
// tb_keypad_decoder: scoreboard bench; a per-scan key-label model predicts every
// pulse and its cycle, and a monitor pops and compares each DUT pulse.
module tb_keypad_decoder;
    localparam int SCAN_DIV = 4, DEB = 2, RDELAY = 6, RRATE = 3, SCAN = 5 * SCAN_DIV;

    logic        clock = 1'b0, reset_n = 1'b0;
    logic [4:0]  col_n;
    logic [3:0]  row_n;
    logic        dig_key, op_key, ex_key, bksp_key, clr_key, ms_key, mr_key, mc_key;
    logic [3:0]  digit_val;
    logic [1:0]  op_sel;
    logic [19:0] held = '0;
    int          cyc = 0, compared = 0, mismatched = 0;
    string       km = "789/B456*c123-rC0=+s";
    string       ops = "+-*/";

    typedef struct { byte lbl; int at; } exp_t;
    exp_t sb[$];

    bit  down;
    byte run_lbl;
    int  run_len, quiet, hold_scans;

    wire [14:0] outs = {dig_key, digit_val, op_key, op_sel, ex_key, bksp_key, clr_key, ms_key, mr_key, mc_key};

    keypad_decoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB), .REPEAT_DELAY(RDELAY), .REPEAT_RATE(RRATE)) dut (
        .clock(clock), .reset_n(reset_n), .col_n(col_n), .row_n(row_n),
        .dig_key(dig_key), .digit_val(digit_val), .op_key(op_key), .op_sel(op_sel),
        .ex_key(ex_key), .bksp_key(bksp_key), .clr_key(clr_key),
        .ms_key(ms_key), .mr_key(mr_key), .mc_key(mc_key)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // A held key pulls its row low only while its own column is driven
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 4; r++) row_n[r] = ~|(held[r*5 +: 5] & ~col_n);
    end

    function automatic logic [19:0] key(input byte l);
        logic [19:0] m = '0;
        for (int i = 0; i < 20; i++) if (km[i] == l) m = 20'd1 << i;
        return m;
    endfunction

    task automatic model_scan(input logic [19:0] m, input int at);
        int  k;
        byte l;
        k = $countones(m);
        l = 0;
        for (int i = 0; i < 20; i++) if (m[i]) l = km[i];
        if (!down) begin
            if (k == 1) begin
                run_len = (run_len > 0 && l == run_lbl) ? run_len + 1 : 1;
                run_lbl = l;
                if (run_len == DEB) begin
                    down = 1; quiet = 0; hold_scans = 0;
                    sb.push_back('{l, at});
                end
            end else run_len = 0;
        end else if (k == 0) begin
            quiet++;
            if (quiet == DEB) begin down = 0; run_len = 0; end
        end else begin
            quiet = 0;
`ifdef KEY_REPEAT_EN
            if (k == 1 && l == run_lbl && ((l >= "0" && l <= "9") || l == "B")) begin
                hold_scans++;
                if (hold_scans >= RDELAY && (hold_scans - RDELAY) % RRATE == 0) sb.push_back('{l, at});
            end
`endif
        end
    endtask

    // Aligns to the first cycle of a scan, so each scan sees one steady key set
    task automatic next_scan(input logic [19:0] m, input bit use_model);
        logic [4:0] prev;
        int n;
        prev = col_n;
        n = 0;
        forever begin
            @(negedge clock);
            n++;
            if (col_n == 5'b11110 && prev != 5'b11110) break;
            prev = col_n;
            if (n > 4 * SCAN) begin
                compared++; mismatched++;
                $display("FAIL scan_align: col_n=%b, column 0 not reached within %0d cycles", col_n, n);
                $fatal(1, "scan alignment lost");
            end
        end
        held = m;
        if (use_model) model_scan(m, cyc + SCAN + 1);
    endtask

    task automatic hold(input logic [19:0] m, input int n);
        for (int i = 0; i < n; i++) next_scan(m, 1);
    endtask

    task automatic check_rst(input string nm);
        compared++;
        if (col_n !== 5'b11111) begin mismatched++; $display("FAIL %s col_n: got %b required 11111", nm, col_n); end
        compared++;
        if (outs !== 15'd0) begin mismatched++; $display("FAIL %s outputs: got %h required 0", nm, outs); end
    endtask

    always @(negedge clock) begin
        int   n;
        byte  got;
        exp_t e;
        n = $countones({dig_key, op_key, ex_key, bksp_key, clr_key, ms_key, mr_key, mc_key});
        if (n != 0) begin
            got = dig_key ? 8'(8'd48 + 8'(digit_val)) : op_key ? ops[op_sel] : ex_key ? "=" :
                  clr_key ? "C" : bksp_key ? "B" : ms_key ? "s" : mr_key ? "r" : "c";
            compared++;
            if (n != 1) begin mismatched++; $display("FAIL onehot: %0d pulses high at cycle %0d, required 1", n, cyc); end
            if (sb.size() == 0) begin
                compared++; mismatched++;
                $display("FAIL unexpected_pulse: key %c at cycle %0d, required no pulse", got, cyc);
            end else begin
                e = sb.pop_front();
                compared++;
                if (got != e.lbl) begin mismatched++; $display("FAIL key: got %c required %c at cycle %0d", got, e.lbl, cyc); end
                if (e.at >= 0) begin
                    compared++;
                    if (cyc != e.at) begin mismatched++; $display("FAIL pulse_time %c: got cycle %0d required %0d", got, cyc, e.at); end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: bench exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        string       seq4;
        int          kind, a, b;
        logic [19:0] m;
        repeat (3) @(negedge clock);
        check_rst("reset_start");
        reset_n = 1'b1;

        hold(key("5"), 10); hold('0, 3);
        hold(key("5"), 3);  hold('0, 3);

        hold('0, 1);
        sb.push_back('{"3", -1});
        for (int i = 0; i < 40; i++) begin
            held = ((i / 3) % 2 == 0) ? key("3") : '0;
            @(negedge clock);
        end
        next_scan(key("3"), 0); next_scan(key("3"), 0);
        down = 1; run_lbl = "3"; run_len = 0; quiet = 0; hold_scans = 0;
        hold('0, 3);

        hold(key("1") | key("2"), 4); hold(key("1"), 3); hold('0, 3);

        seq4 = "+/=CBsrc";
        for (int i = 0; i < seq4.len(); i++) begin hold(key(seq4[i]), 3); hold('0, 3); end

        next_scan(key("7"), 1);
        repeat (25) @(negedge clock);
        reset_n = 1'b0;
        #1 check_rst("reset_mid_press");
        down = 0; run_len = 0; quiet = 0;
        repeat (3) @(negedge clock);
        check_rst("reset_hold");
        reset_n = 1'b1;
        hold(key("7"), 3); hold('0, 3);

`ifdef KEY_REPEAT_EN
        hold(key("9"), 14); hold('0, 3);
        hold(key("*"), 14); hold('0, 3);
`endif

        for (int s = 0; s < 80; s++) begin
            kind = $urandom_range(0, 99);
            a = $urandom_range(0, 19);
            b = $urandom_range(0, 19);
            m = '0;
            if (kind >= 40) m[a] = 1'b1;
            if (kind >= 85) m[b] = 1'b1;
            hold(m, $urandom_range(1, 4));
        end
        hold('0, 4);

        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL missing_pulses: %0d expected pulses never seen, required 0 (next %c)", sb.size(), sb[0].lbl);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
